md_issue_ctrl: RTL and testbench

Initiator-side controller for the multiply/divide unit. Sits in the E stage between the decoded instruction and the MD unit.
- Turns E-stage mult/multu/div/divu/mthi/mtlo into the unit's start / HI-LO-write handshake.
- Suppresses issue when an exception/interrupt request is raised.
- Produces the D-stage stall for MD-class instructions and the mfhi/mflo read data.
- Independently tracks in-flight latency and flags protocol violations (busy too short or too long).

---
 rtl/md_issue_ctrl_pkg.sv | 43 ++++
 rtl/md_lat_watch.sv | 84 ++++++++
 rtl/md_issue_ctrl.sv | 66 ++++++
 tb/tb_md_issue_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_issue_ctrl_pkg.sv
// Shared op codes, ALU op constants and controller state for the MD issue path.
package md_issue_ctrl_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_MFX   = 3'd7
  } md_op_e;

  localparam logic [5:0] ALU_MUL  = 6'h18;
  localparam logic [5:0] ALU_MULU = 6'h19;
  localparam logic [5:0] ALU_DIV  = 6'h1a;
  localparam logic [5:0] ALU_DIVU = 6'h1b;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } md_state_e;

  function automatic logic is_muldiv(md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_div(md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic [5:0] md_aluop(md_op_e op);
    case (op)
      MD_MULT:  return ALU_MUL;
      MD_MULTU: return ALU_MULU;
      MD_DIV:   return ALU_DIV;
      MD_DIVU:  return ALU_DIVU;
      default:  return 6'd0;
    endcase
  endfunction

endpackage

// File: rtl/md_lat_watch.sv
// Tracks one in-flight MD operation and flags busy windows that are too short or too long.
module md_lat_watch
  import md_issue_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10,
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  input  logic is_div_i,
  input  logic busy_i,
  output logic inflight_o,
  output logic timeout_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_C = CW'(TIMEOUT);
  localparam logic [CW-1:0] MUL_C = CW'(MUL_LAT);
  localparam logic [CW-1:0] DIV_C = CW'(DIV_LAT);

  md_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] lat_q, lat_d;
  logic [CW-1:0] cnt_now;
  logic          tmo_q, tmo_d;

  // cnt_q holds completed WAIT cycles, so cnt_now is the position of the current cycle after start.
  assign cnt_now = (cnt_q >= TMO_C) ? TMO_C : cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      lat_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    tmo_d   = tmo_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_WAIT;
          lat_d   = is_div_i ? DIV_C : MUL_C;
          cnt_d   = '0;
        end
      end
      ST_WAIT: begin
        if (start_i) begin
          // Restart while a previous op is still tracked: protocol error, track the new one.
          tmo_d = 1'b1;
          lat_d = is_div_i ? DIV_C : MUL_C;
          cnt_d = '0;
        end else if (!busy_i) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          if (cnt_now != lat_q + 1'b1) tmo_d = 1'b1;
        end else if (cnt_now == TMO_C) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_now;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign inflight_o = (state_q == ST_WAIT);
  assign timeout_o  = tmo_q;

endmodule

// File: rtl/md_issue_ctrl.sv
// E-stage issue controller for the multiply/divide unit: start/HI-LO write decode, D stall, mfhi/mflo mux.
module md_issue_ctrl
  import md_issue_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10,
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        e_valid,
  input  logic [2:0]  e_op,
  input  logic [31:0] e_rs,
  input  logic [31:0] e_rt,
  input  logic        e_rd_hi,
  input  logic        d_md_use,
  input  logic        md_busy,
  input  logic [31:0] md_HI,
  input  logic [31:0] md_LO,
  output logic        md_start,
  output logic        md_hilowe,
  output logic        md_hilo_A3,
  output logic [5:0]  md_ALUop,
  output logic [31:0] md_rs,
  output logic [31:0] md_rt,
  output logic [31:0] md_rdata,
  output logic        stall_md,
  output logic        inflight,
  output logic        timeout
);

  md_op_e op;
  logic   iss;

  assign op  = md_op_e'(e_op);
  assign iss = e_valid & ~req;

  assign md_start   = iss & is_muldiv(op);
  assign md_ALUop   = md_aluop(op);
  assign md_hilowe  = iss & ((op == MD_MTHI) | (op == MD_MTLO));
  assign md_hilo_A3 = (op == MD_MTLO);
  assign md_rs      = e_rs;
  assign md_rt      = e_rt;

  // Straight from the unit's registers; an in-flight result is not bypassed.
  assign md_rdata = e_rd_hi ? md_HI : md_LO;

  // Busy only rises the cycle after start, so the start cycle stalls on md_start itself.
  assign stall_md = d_md_use & (md_start | md_busy | inflight);

  md_lat_watch #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT),
    .TIMEOUT (TIMEOUT)
  ) u_lat_watch (
    .clk        (clk),
    .reset      (reset),
    .start_i    (md_start),
    .is_div_i   (is_div(op)),
    .busy_i     (md_busy),
    .inflight_o (inflight),
    .timeout_o  (timeout)
  );

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Self-checking bench for md_issue_ctrl with a stub MD unit and a cycle-age reference model.
module tb_md_issue_ctrl;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset, req, e_valid, e_rd_hi, d_md_use;
  logic [2:0]  e_op;
  logic [31:0] e_rs, e_rt;
  logic        md_busy;
  logic [31:0] md_HI, md_LO;
  logic        md_start, md_hilowe, md_hilo_A3, stall_md, inflight, timeout;
  logic [5:0]  md_ALUop;
  logic [31:0] md_rs, md_rt, md_rdata;

  int vecs = 0;
  int errs = 0;

  md_issue_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req), .e_valid(e_valid), .e_op(e_op),
    .e_rs(e_rs), .e_rt(e_rt), .e_rd_hi(e_rd_hi), .d_md_use(d_md_use),
    .md_busy(md_busy), .md_HI(md_HI), .md_LO(md_LO),
    .md_start(md_start), .md_hilowe(md_hilowe), .md_hilo_A3(md_hilo_A3),
    .md_ALUop(md_ALUop), .md_rs(md_rs), .md_rt(md_rt), .md_rdata(md_rdata),
    .stall_md(stall_md), .inflight(inflight), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Stub MD unit: busy for the op's latency (or an override), results written at start.
  bit          stub_rst;
  int          bcnt;
  int          busy_ovr;
  logic [31:0] hi_q, lo_q;
  assign md_busy = (bcnt != 0);
  assign md_HI   = hi_q;
  assign md_LO   = lo_q;

  always @(posedge clk) begin
    if (stub_rst) begin
      bcnt <= 0; hi_q <= '0; lo_q <= '0;
    end else begin
      if (md_start) begin
        if (busy_ovr != 0) bcnt <= busy_ovr;
        else bcnt <= (md_ALUop == 6'h1a || md_ALUop == 6'h1b) ? DIV_LAT : MUL_LAT;
        case (md_ALUop)
          6'h18: {hi_q, lo_q} <= 64'($signed(md_rs)) * 64'($signed(md_rt));
          6'h19: {hi_q, lo_q} <= {32'd0, md_rs} * {32'd0, md_rt};
          6'h1a: if (md_rt != 0) begin
                   lo_q <= $signed(md_rs) / $signed(md_rt);
                   hi_q <= $signed(md_rs) % $signed(md_rt);
                 end
          6'h1b: if (md_rt != 0) begin
                   lo_q <= md_rs / md_rt;
                   hi_q <= md_rs % md_rt;
                 end
          default: ;
        endcase
      end else if (bcnt > 0) begin
        bcnt <= bcnt - 1;
      end
      if (md_hilowe) begin
        if (md_hilo_A3) lo_q <= md_rs;
        else hi_q <= md_rs;
      end
    end
  end

  // Reference model: whether an op is outstanding, how many cycles since its start, sticky error.
  bit m_wait, m_tmo;
  int m_age, m_lat;

  function automatic bit is_md(logic [2:0] op);
    return (op >= 3'd1) && (op <= 3'd4);
  endfunction

  function automatic logic [5:0] alu_of(logic [2:0] op);
    case (op)
      3'd1: return 6'h18;
      3'd2: return 6'h19;
      3'd3: return 6'h1a;
      3'd4: return 6'h1b;
      default: return 6'h00;
    endcase
  endfunction

  wire [107:0] obs = {md_start, md_hilowe, md_hilo_A3, md_ALUop, stall_md, inflight,
                      timeout, md_rdata, md_rs, md_rt};

  function automatic logic [107:0] exp_vec();
    logic s;
    s = e_valid && !req && is_md(e_op);
    return {s, e_valid && !req && (e_op == 3'd5 || e_op == 3'd6), e_op == 3'd6,
            alu_of(e_op), d_md_use && (s || md_busy || m_wait), m_wait, m_tmo,
            e_rd_hi ? md_HI : md_LO, e_rs, e_rt};
  endfunction

  task automatic tick();
    bit st, rst, b;
    logic [2:0] op;
    st  = e_valid && !req && is_md(e_op);
    rst = reset;
    b   = md_busy;
    op  = e_op;
    @(posedge clk);
    if (rst) begin
      m_wait = 0; m_tmo = 0; m_age = 0;
    end else if (st) begin
      if (m_wait) m_tmo = 1;
      m_wait = 1; m_age = 1;
      m_lat  = (op == 3'd3 || op == 3'd4) ? DIV_LAT : MUL_LAT;
    end else if (m_wait) begin
      if (!b) begin
        m_wait = 0;
        if (m_age != m_lat + 1) m_tmo = 1;
      end else if (m_age >= TIMEOUT) begin
        m_wait = 0; m_tmo = 1;
      end else begin
        m_age++;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    req = 0; e_valid = 0; e_op = 3'd0; e_rd_hi = 0; d_md_use = 0;
  endtask

  task automatic drain();
    idle_inputs();
    for (int i = 0; i < 40 && (md_busy || inflight); i++) tick();
  endtask

  task automatic test_reset();
    stub_rst = 1; reset = 1; busy_ovr = 0;
    idle_inputs(); e_rs = 0; e_rt = 0;
    tick(); tick();
    stub_rst = 0; reset = 0;
    #1;
    vecs++;
    if ({inflight, timeout, md_start, stall_md} !== 4'b0000) begin
      errs++; $display("FAIL reset_state got=%b exp=0000", {inflight, timeout, md_start, stall_md});
    end
    vecs++;
    if (obs !== exp_vec()) begin errs++; $display("FAIL reset_vec got=%h exp=%h", obs, exp_vec()); end
  endtask

  task automatic test_mult();
    int n_in;
    n_in = 0;
    e_valid = 1; e_op = 3'd1; e_rs = 32'd3; e_rt = 32'hFFFF_FFFE; d_md_use = 1;
    #1;
    vecs++;
    if (md_start !== 1'b1 || md_ALUop !== 6'h18 || stall_md !== 1'b1) begin
      errs++; $display("FAIL mult_issue got=%b/%h/%b exp=1/18/1", md_start, md_ALUop, stall_md);
    end
    tick();
    e_valid = 0; e_op = 3'd0;
    for (int i = 1; i <= 9; i++) begin
      #1;
      vecs++;
      if (obs !== exp_vec()) begin errs++; $display("FAIL mult_c%0d got=%h exp=%h", i, obs, exp_vec()); end
      if (inflight) n_in++;
      tick();
    end
    vecs++;
    if (n_in !== MUL_LAT + 1 || timeout !== 1'b0) begin
      errs++; $display("FAIL mult_window got=%0d/%b exp=%0d/0", n_in, timeout, MUL_LAT + 1);
    end
    e_valid = 1; e_op = 3'd7; e_rd_hi = 1; #1;
    vecs++;
    if (md_rdata !== 32'hFFFF_FFFF) begin errs++; $display("FAIL mult_hi got=%h exp=ffffffff", md_rdata); end
    e_rd_hi = 0; #1;
    vecs++;
    if (md_rdata !== 32'hFFFF_FFFA) begin errs++; $display("FAIL mult_lo got=%h exp=fffffffa", md_rdata); end
    tick();
  endtask

  task automatic test_divu();
    idle_inputs();
    e_valid = 1; e_op = 3'd4; e_rs = 32'd100; e_rt = 32'd7;
    #1;
    vecs++;
    if (md_start !== 1'b1 || md_ALUop !== 6'h1b) begin
      errs++; $display("FAIL divu_issue got=%b/%h exp=1/1b", md_start, md_ALUop);
    end
    tick();
    e_valid = 0; e_op = 3'd0;
    for (int i = 1; i <= 13; i++) begin
      #1;
      vecs++;
      if (inflight !== (i <= DIV_LAT + 1) || obs !== exp_vec()) begin
        errs++; $display("FAIL divu_c%0d got=%h exp=%h", i, obs, exp_vec());
      end
      tick();
    end
    e_valid = 1; e_op = 3'd7; e_rd_hi = 1; #1;
    vecs++;
    if (md_rdata !== 32'd2) begin errs++; $display("FAIL divu_hi got=%0d exp=2", md_rdata); end
    e_rd_hi = 0; #1;
    vecs++;
    if (md_rdata !== 32'd14 || timeout !== 1'b0) begin
      errs++; $display("FAIL divu_lo got=%0d/%b exp=14/0", md_rdata, timeout);
    end
    tick();
  endtask

  task automatic test_mtlo();
    idle_inputs();
    e_valid = 1; e_op = 3'd6; e_rs = 32'hDEAD_BEEF; d_md_use = 1;
    #1;
    vecs++;
    if ({md_hilowe, md_hilo_A3, md_start, stall_md} !== 4'b1100) begin
      errs++; $display("FAIL mtlo_issue got=%b exp=1100", {md_hilowe, md_hilo_A3, md_start, stall_md});
    end
    tick();
    e_op = 3'd7; e_rd_hi = 0; #1;
    vecs++;
    if (md_rdata !== 32'hDEAD_BEEF || stall_md !== 1'b0) begin
      errs++; $display("FAIL mtlo_read got=%h/%b exp=deadbeef/0", md_rdata, stall_md);
    end
    tick();
  endtask

  task automatic test_req_cancel();
    idle_inputs();
    e_valid = 1; e_op = 3'd1; req = 1; d_md_use = 1; e_rs = 32'd5; e_rt = 32'd6;
    #1;
    vecs++;
    if (md_start !== 1'b0 || stall_md !== 1'b0) begin
      errs++; $display("FAIL req_issue got=%b/%b exp=0/0", md_start, stall_md);
    end
    tick();
    idle_inputs(); #1;
    vecs++;
    if (inflight !== 1'b0 || md_busy !== 1'b0 || obs !== exp_vec()) begin
      errs++; $display("FAIL req_state got=%b/%b exp=0/0", inflight, md_busy);
    end
    tick();
  endtask

  task automatic test_timeout();
    bit seen;
    // Busy too short on a DIV.
    busy_ovr = 2;
    e_valid = 1; e_op = 3'd3; e_rs = 32'd50; e_rt = 32'd3; tick();
    idle_inputs();
    for (int i = 1; i <= 4; i++) begin
      #1;
      vecs++;
      if (obs !== exp_vec()) begin errs++; $display("FAIL early_c%0d got=%h exp=%h", i, obs, exp_vec()); end
      tick();
    end
    vecs++;
    if (timeout !== 1'b1 || inflight !== 1'b0) begin
      errs++; $display("FAIL early_flag got=%b/%b exp=1/0", timeout, inflight);
    end
    // A clean MULT afterwards leaves the flag set.
    busy_ovr = 0;
    e_valid = 1; e_op = 3'd1; tick();
    drain();
    vecs++;
    if (timeout !== 1'b1) begin errs++; $display("FAIL sticky got=%b exp=1", timeout); end
    reset = 1; tick(); reset = 0; #1;
    vecs++;
    if (timeout !== 1'b0) begin errs++; $display("FAIL tmo_clear got=%b exp=0", timeout); end
    // Busy held far too long.
    busy_ovr = 20;
    e_valid = 1; e_op = 3'd1; tick();
    idle_inputs();
    seen = 0;
    for (int i = 1; i <= 18; i++) begin
      #1;
      vecs++;
      if (obs !== exp_vec() || timeout !== (i > TIMEOUT) || inflight !== (i <= TIMEOUT)) begin
        errs++; $display("FAIL late_c%0d got=%h exp=%h", i, obs, exp_vec());
      end
      if (timeout) seen = 1;
      tick();
    end
    vecs++;
    if (!seen) begin errs++; $display("FAIL late_flag got=0 exp=1"); end
    busy_ovr = 0;
    drain();
    reset = 1; tick(); reset = 0; #1;
    vecs++;
    if (timeout !== 1'b0) begin errs++; $display("FAIL late_clear got=%b exp=0", timeout); end
  endtask

  task automatic test_reset_mid_wait();
    idle_inputs();
    e_valid = 1; e_op = 3'd1; d_md_use = 1; tick();
    e_valid = 0; e_op = 3'd0;
    tick(); tick();
    reset = 1; tick(); reset = 0;
    #1;
    vecs++;
    if (inflight !== 1'b0 || timeout !== 1'b0 || stall_md !== md_busy || md_busy !== 1'b1) begin
      errs++; $display("FAIL rst_mid got=%b/%b/%b exp=0/0/1", inflight, timeout, stall_md);
    end
    vecs++;
    if (obs !== exp_vec()) begin errs++; $display("FAIL rst_mid_vec got=%h exp=%h", obs, exp_vec()); end
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      e_op     = 3'($urandom_range(0, 7));
      e_valid  = ($urandom_range(0, 3) != 0);
      req      = ($urandom_range(0, 5) == 0);
      d_md_use = $urandom_range(0, 1) == 1;
      e_rd_hi  = $urandom_range(0, 1) == 1;
      e_rs     = $urandom;
      e_rt     = $urandom;
      reset    = ($urandom_range(0, 99) == 0);
      busy_ovr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : 0;
      #1;
      vecs++;
      if (obs !== exp_vec()) begin errs++; $display("FAIL rand_c%0d got=%h exp=%h", i, obs, exp_vec()); end
      tick();
    end
    reset = 0; busy_ovr = 0;
    drain();
  endtask

  initial begin
    test_reset();
    test_mult();
    drain();
    test_divu();
    drain();
    test_mtlo();
    test_req_cancel();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
